// File: rtl/tick_gen_multi.sv
// tick_gen_multi: N-channel periodic enable generator.
// Each channel counts through a runtime-loadable divisor and emits a one-cycle
// registered tick when its counter is at zero. A channel can run periodically or
// fire a single tick and then wait to be re-armed. One shared sync_clr restarts
// every channel in phase.
module tick_gen_multi #(
  parameter int                    N_CH     = 3,
  parameter int                    CNT_W    = 24,
  parameter logic [N_CH*CNT_W-1:0] DIV_INIT = {N_CH{CNT_W'(2)}},
  parameter int                    SEL_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  ch_en,
  input  logic [N_CH-1:0]  oneshot,
  input  logic             sync_clr,
  input  logic             div_wr,
  input  logic [SEL_W-1:0] div_sel,
  input  logic [CNT_W-1:0] div_wdata,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  armed
);

  logic [CNT_W-1:0] div_q  [N_CH];
  logic [CNT_W-1:0] cnt_q  [N_CH];
  logic [CNT_W-1:0] de     [N_CH];
  logic [N_CH-1:0]  wr_hit;
  logic [N_CH-1:0]  restart;
  logic [N_CH-1:0]  at_zero;
  logic [N_CH-1:0]  at_wrap;

  // Per-channel decode: effective divisor (0 behaves as 1), write hit, restart and counter flags.
  // A div_sel beyond the last channel matches no channel, so such a write is ignored.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      de[i]      = (div_q[i] == '0) ? CNT_W'(1) : div_q[i];
      wr_hit[i]  = div_wr && (div_sel == SEL_W'(i));
      restart[i] = sync_clr || !ch_en[i] || wr_hit[i];
      at_zero[i] = (cnt_q[i] == '0);
      at_wrap[i] = (cnt_q[i] >= de[i] - CNT_W'(1));
    end
  end

  // Divisor registers: loaded from DIV_INIT on reset, updated by a div_wr to the channel
  // even when the same edge also restarts or idles that channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        div_q[i] <= DIV_INIT[i*CNT_W +: CNT_W];
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (wr_hit[i]) begin
          div_q[i] <= div_wdata;
        end
      end
    end
  end

  // Counter, tick and armed state per channel. Restart (sync_clr, idle, divisor write)
  // wins; a disarmed one-shot holds its count; otherwise the counter wraps with >= so a
  // counter that is somehow above a shrunk divisor still wraps instead of running away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= '0;
      end
      tick  <= '0;
      armed <= '1;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (restart[i]) begin
          cnt_q[i] <= '0;
          tick[i]  <= 1'b0;
          armed[i] <= 1'b1;
        end else if (!armed[i]) begin
          tick[i] <= 1'b0;
          if (!oneshot[i]) begin
            armed[i] <= 1'b1;
          end
        end else begin
          tick[i]  <= at_zero[i];
          cnt_q[i] <= at_wrap[i] ? '0 : cnt_q[i] + CNT_W'(1);
          if (oneshot[i] && at_zero[i]) begin
            armed[i] <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_tick_gen_multi.sv
// tb_tick_gen_multi: directed scenarios plus random traffic for tick_gen_multi,
// compared every cycle against a model that tracks elapsed run cycles per channel.
module tb_tick_gen_multi;

  localparam int N_CH  = 3;
  localparam int CNT_W = 24;
  localparam int SEL_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N_CH-1:0]  ch_en;
  logic [N_CH-1:0]  oneshot;
  logic             sync_clr;
  logic             div_wr;
  logic [SEL_W-1:0] div_sel;
  logic [CNT_W-1:0] div_wdata;
  logic [N_CH-1:0]  tick;
  logic [N_CH-1:0]  armed;

  int checks   = 0;
  int failures = 0;

  // Reference model: divisor, number of run cycles since the last restart, outputs.
  int              m_div [N_CH];
  int              m_el  [N_CH];
  logic [N_CH-1:0] exp_tick;
  logic [N_CH-1:0] exp_armed;

  tick_gen_multi #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ch_en     (ch_en),
    .oneshot   (oneshot),
    .sync_clr  (sync_clr),
    .div_wr    (div_wr),
    .div_sel   (div_sel),
    .div_wdata (div_wdata),
    .tick      (tick),
    .armed     (armed)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < N_CH; i++) begin
      m_div[i] = 2;
      m_el[i]  = 0;
    end
    exp_tick  = '0;
    exp_armed = '1;
  endtask

  // A channel ticks when its elapsed run count is a multiple of the divisor; a one-shot
  // stops after its first tick until something restarts it.
  task automatic step();
    for (int i = 0; i < N_CH; i++) begin
      bit wr;
      int dv;
      wr = div_wr && (int'(div_sel) == i);
      dv = (m_div[i] == 0) ? 1 : m_div[i];
      if (wr) m_div[i] = int'(div_wdata);
      if (sync_clr || !ch_en[i] || wr) begin
        m_el[i] = 0;
        exp_tick[i] = 1'b0;
        exp_armed[i] = 1'b1;
      end else if (!exp_armed[i]) begin
        exp_tick[i] = 1'b0;
        if (!oneshot[i]) exp_armed[i] = 1'b1;
      end else begin
        exp_tick[i] = ((m_el[i] % dv) == 0);
        m_el[i]++;
        if (oneshot[i] && exp_tick[i]) exp_armed[i] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ch_en = '0; oneshot = '0; sync_clr = 1'b0;
    div_wr = 1'b0; div_sel = '0; div_wdata = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (tick !== 3'b000 || armed !== 3'b111) begin
      failures++;
      $display("[TB] FAIL reset_state tick=%b armed=%b required tick=000 armed=111", tick, armed);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (tick !== exp_tick || armed !== exp_armed) begin
        failures++;
        $display("[TB] FAIL reset_idle c=%0d tick=%b armed=%b required tick=%b armed=%b", c, tick, armed, exp_tick, exp_armed);
      end
    end
  endtask

  task automatic test_default_period();
    ch_en = 3'b001;
    for (int c = 0; c < 8; c++) begin
      step();
      checks++;
      if (tick !== exp_tick || armed !== exp_armed) begin
        failures++;
        $display("[TB] FAIL default_period c=%0d tick=%b armed=%b required tick=%b armed=%b", c, tick, armed, exp_tick, exp_armed);
      end
      checks++;
      if (tick[0] !== ((c % 2) == 0)) begin
        failures++;
        $display("[TB] FAIL default_pattern c=%0d tick0=%b required %b", c, tick[0], (c % 2) == 0);
      end
    end
  endtask

  task automatic test_div_write();
    int seen [$];
    div_wr = 1'b1; div_sel = 2'd1; div_wdata = 24'd5;
    step();
    div_wr = 1'b0;
    ch_en = 3'b011;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (tick[1]) seen.push_back(c);
      checks++;
      if (tick !== exp_tick || armed !== exp_armed) begin
        failures++;
        $display("[TB] FAIL div5_run c=%0d tick=%b armed=%b required tick=%b armed=%b", c, tick, armed, exp_tick, exp_armed);
      end
    end
    checks++;
    if (seen.size() != 3 || seen[0] != 1 || seen[1] != 6 || seen[2] != 11) begin
      failures++;
      $display("[TB] FAIL div5_ticks count=%0d required ticks at enable+1,+6,+11", seen.size());
    end
    div_wr = 1'b1; div_sel = 2'd1; div_wdata = 24'd0;
    step();
    div_wr = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if (tick[1] !== 1'b1 || tick !== exp_tick) begin
        failures++;
        $display("[TB] FAIL div0_every_cycle c=%0d tick=%b required tick=%b", c, tick, exp_tick);
      end
    end
  endtask

  task automatic test_shrink();
    ch_en = 3'b001;
    div_wr = 1'b1; div_sel = 2'd0; div_wdata = 24'd10;
    step();
    div_wr = 1'b0;
    repeat (7) step();
    checks++;
    if (dut.cnt_q[0] !== 24'd7) begin
      failures++;
      $display("[TB] FAIL shrink_precount cnt=%0d required 7", dut.cnt_q[0]);
    end
    div_wr = 1'b1; div_sel = 2'd0; div_wdata = 24'd3;
    step();
    div_wr = 1'b0;
    for (int c = 0; c < 12; c++) begin
      step();
      checks++;
      if (tick !== exp_tick || dut.cnt_q[0] > 24'd2 || tick[0] !== ((c % 3) == 0)) begin
        failures++;
        $display("[TB] FAIL shrink_run c=%0d tick=%b cnt=%0d required tick=%b cnt<=2", c, tick, dut.cnt_q[0], exp_tick);
      end
    end
  endtask

  task automatic test_oneshot();
    int n;
    ch_en = 3'b000;
    oneshot = 3'b100;
    div_wr = 1'b1; div_sel = 2'd2; div_wdata = 24'd4;
    step();
    div_wr = 1'b0;
    ch_en = 3'b100;
    n = 0;
    for (int c = 0; c < 25; c++) begin
      step();
      if (tick[2]) n++;
      checks++;
      if (tick !== exp_tick || armed !== exp_armed) begin
        failures++;
        $display("[TB] FAIL oneshot_run c=%0d tick=%b armed=%b required tick=%b armed=%b", c, tick, armed, exp_tick, exp_armed);
      end
    end
    checks++;
    if (n != 1 || armed[2] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL oneshot_single ticks=%0d armed2=%b required ticks=1 armed2=0", n, armed[2]);
    end
    ch_en = 3'b000;
    step();
    ch_en = 3'b100;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (tick[2]) n++;
    end
    checks++;
    if (n != 1 || armed !== exp_armed) begin
      failures++;
      $display("[TB] FAIL oneshot_rearm ticks=%0d armed=%b required ticks=1 armed=%b", n, armed, exp_armed);
    end
    oneshot = 3'b000;
    for (int c = 0; c < 6; c++) begin
      step();
      checks++;
      if (tick !== exp_tick || armed !== exp_armed) begin
        failures++;
        $display("[TB] FAIL oneshot_clear c=%0d tick=%b armed=%b required tick=%b armed=%b", c, tick, armed, exp_tick, exp_armed);
      end
    end
  endtask

  task automatic test_sync_clr();
    oneshot = '0;
    ch_en = '0;
    for (int i = 0; i < N_CH; i++) begin
      div_wr = 1'b1; div_sel = SEL_W'(i); div_wdata = CNT_W'(3 + 2 * i);
      step();
    end
    div_wr = 1'b0;
    ch_en = 3'b111;
    repeat (13) step();
    sync_clr = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (tick !== 3'b000 || armed !== 3'b111) begin
        failures++;
        $display("[TB] FAIL sync_clr_hold c=%0d tick=%b armed=%b required tick=000 armed=111", c, tick, armed);
      end
    end
    sync_clr = 1'b0;
    step();
    checks++;
    if (tick !== 3'b111 || tick !== exp_tick) begin
      failures++;
      $display("[TB] FAIL sync_clr_release tick=%b required 111", tick);
    end
    repeat (4) step();
    sync_clr = 1'b1;
    div_wr = 1'b1; div_sel = 2'd0; div_wdata = 24'd4;
    step();
    sync_clr = 1'b0;
    div_wr = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      checks++;
      if (tick !== exp_tick || armed !== exp_armed || tick[0] !== ((c % 4) == 0)) begin
        failures++;
        $display("[TB] FAIL sync_clr_wr c=%0d tick=%b armed=%b required tick=%b armed=%b", c, tick, armed, exp_tick, exp_armed);
      end
    end
  endtask

  task automatic test_bad_sel_and_reset();
    div_wr = 1'b1; div_sel = 2'd3; div_wdata = 24'd1;
    step();
    div_wr = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      checks++;
      if (tick !== exp_tick || armed !== exp_armed) begin
        failures++;
        $display("[TB] FAIL bad_sel c=%0d tick=%b armed=%b required tick=%b armed=%b", c, tick, armed, exp_tick, exp_armed);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (tick !== 3'b000 || armed !== 3'b111 || dut.div_q[0] !== 24'd2 ||
        dut.div_q[1] !== 24'd2 || dut.div_q[2] !== 24'd2) begin
      failures++;
      $display("[TB] FAIL async_reset tick=%b armed=%b div0=%0d div1=%0d div2=%0d required tick=000 armed=111 div=2",
               tick, armed, dut.div_q[0], dut.div_q[1], dut.div_q[2]);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    ch_en = 3'b111;
    for (int c = 0; c < 6; c++) begin
      step();
      checks++;
      if (tick !== exp_tick || tick !== (((c % 2) == 0) ? 3'b111 : 3'b000)) begin
        failures++;
        $display("[TB] FAIL post_reset c=%0d tick=%b required tick=%b", c, tick, exp_tick);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N_CH; i++) begin
        ch_en[i] = ($urandom_range(0, 9) != 0);
        if ($urandom_range(0, 19) == 0) oneshot[i] = ~oneshot[i];
      end
      sync_clr = ($urandom_range(0, 19) == 0);
      div_wr = ($urandom_range(0, 11) == 0);
      div_sel = SEL_W'($urandom_range(0, 3));
      div_wdata = CNT_W'($urandom_range(0, 6));
      step();
      checks++;
      if (tick !== exp_tick || armed !== exp_armed) begin
        failures++;
        $display("[TB] FAIL random c=%0d tick=%b armed=%b required tick=%b armed=%b", c, tick, armed, exp_tick, exp_armed);
      end
    end
  endtask

  initial begin
    test_reset();
    test_default_period();
    test_div_write();
    test_shrink();
    test_oneshot();
    test_sync_clr();
    test_bad_sel_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
